// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: width macros, funct3 codes,
// FSM/owner encodings and the pipeline access legality helpers.
`ifndef MEM
`define MEM 32
`endif
`ifndef MEM_ADDR
`define MEM_ADDR 32
`endif

package dmem_ctrl_pkg;

  localparam int DATA_W = `MEM;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic {
    OWN_PIPE = 1'b0,
    OWN_DBG  = 1'b1
  } owner_e;

  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // funct3[1:0] carries the access size for both loads and stores.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (f3[1:0])
      2'b01:   bad = addr_lo[0];
      2'b10:   bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane handling for data-memory accesses: byte enables and write-data
// replication on the request side, lane select and sign/zero extension on loads.
module dmem_lane_align
  import dmem_ctrl_pkg::*;
(
  input  logic [2:0]        req_funct3,
  input  logic [1:0]        req_addr_lo,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        rsp_funct3,
  input  logic [1:0]        rsp_addr_lo,
  input  logic [DATA_W-1:0] rsp_rdata,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_ext
);

  logic [DATA_W-1:0] rd_shift;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    be    = 4'b1111;
    wdata = req_wdata;
    case (req_funct3[1:0])
      F3_SB[1:0]: begin
        be    = 4'b0001 << req_addr_lo;
        wdata = {4{req_wdata[7:0]}};
      end
      F3_SH[1:0]: begin
        be    = 4'b0011 << {req_addr_lo[1], 1'b0};
        wdata = {2{req_wdata[15:0]}};
      end
      F3_SW[1:0], 2'b11: begin
        be    = 4'b1111;
        wdata = req_wdata;
      end
    endcase
  end

  // Halfword loads are aligned, so a shift by 0 or 16 picks the right half.
  assign rd_shift = rsp_rdata >> {rsp_addr_lo, 3'b000};
  assign rd_byte  = rd_shift[7:0];
  assign rd_half  = rd_shift[15:0];

  always_comb begin
    rdata_ext = rsp_rdata;
    case (rsp_funct3)
      F3_LB:   rdata_ext = {{24{rd_byte[7]}}, rd_byte};
      F3_LH:   rdata_ext = {{16{rd_half[15]}}, rd_half};
      F3_LBU:  rdata_ext = {24'd0, rd_byte};
      F3_LHU:  rdata_ext = {16'd0, rd_half};
      F3_LW:   rdata_ext = rsp_rdata;
      default: rdata_ext = rsp_rdata;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: sequences MEM-stage loads/stores onto a req/gnt/rvalid RAM.
// Define DMEM_DBG_PORT_EN to add the debug/loader port with round-robin arbitration.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = `MEM_ADDR,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              pipe_req_i,
  input  logic              pipe_we_i,
  input  logic [2:0]        pipe_funct3_i,
  input  logic [ADDR_W-1:0] pipe_addr_i,
  input  logic [DATA_W-1:0] pipe_wdata_i,
  output logic              pipe_stall_o,
  output logic              pipe_done_o,
  output logic              pipe_err_o,
  output logic [DATA_W-1:0] pipe_rdata_o,
`ifdef DMEM_DBG_PORT_EN
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_done_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
`endif
  output logic              ram_req_o,
  output logic              ram_we_o,
  output logic [ADDR_W-3:0] ram_addr_o,
  output logic [3:0]        ram_be_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic              ram_gnt_i,
  input  logic              ram_rvalid_i,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_e           state;
  owner_e           owner;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       cur_funct3;
  logic [1:0]       cur_addr_lo;

  logic              any_req;
  logic              pipe_bad;
  logic              timeout_hit;
  logic [3:0]        pipe_be;
  logic [DATA_W-1:0] pipe_wdata_rep;
  logic [DATA_W-1:0] rdata_ext;

`ifdef DMEM_DBG_PORT_EN
  owner_e last_owner;
  logic   grant_dbg;
  logic   unused_dbg_addr_lo;

  assign unused_dbg_addr_lo = ^dbg_addr_i[1:0];
  assign any_req   = pipe_req_i || dbg_req_i;
  // Debug wins when alone, or on a conflict when the pipeline was served last.
  assign grant_dbg = dbg_req_i && (!pipe_req_i || (last_owner == OWN_PIPE));
`else
  assign any_req = pipe_req_i;
`endif

  assign pipe_bad    = f3_illegal(pipe_funct3_i) || misaligned(pipe_funct3_i, pipe_addr_i[1:0]);
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == TO_LAST);

  // Released exactly in the pipeline's own DONE cycle so the stage advances once.
  assign pipe_stall_o = pipe_req_i && !((state == ST_DONE) && (owner == OWN_PIPE));

  dmem_lane_align u_lane_align (
    .req_funct3  (pipe_funct3_i),
    .req_addr_lo (pipe_addr_i[1:0]),
    .req_wdata   (pipe_wdata_i),
    .rsp_funct3  (cur_funct3),
    .rsp_addr_lo (cur_addr_lo),
    .rsp_rdata   (ram_rdata_i),
    .be          (pipe_be),
    .wdata       (pipe_wdata_rep),
    .rdata_ext   (rdata_ext)
  );

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state        <= ST_IDLE;
      owner        <= OWN_PIPE;
      cnt          <= '0;
      cur_funct3   <= '0;
      cur_addr_lo  <= '0;
      ram_req_o    <= 1'b0;
      ram_we_o     <= 1'b0;
      ram_addr_o   <= '0;
      ram_be_o     <= '0;
      ram_wdata_o  <= '0;
      pipe_done_o  <= 1'b0;
      pipe_err_o   <= 1'b0;
      pipe_rdata_o <= '0;
`ifdef DMEM_DBG_PORT_EN
      last_owner   <= OWN_DBG;
      dbg_done_o   <= 1'b0;
      dbg_rdata_o  <= '0;
`endif
    end else begin
      pipe_done_o <= 1'b0;
      pipe_err_o  <= 1'b0;
`ifdef DMEM_DBG_PORT_EN
      dbg_done_o  <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (any_req) begin
`ifdef DMEM_DBG_PORT_EN
            if (grant_dbg) begin
              owner       <= OWN_DBG;
              last_owner  <= OWN_DBG;
              cur_funct3  <= F3_LW;
              cur_addr_lo <= 2'b00;
              ram_req_o   <= 1'b1;
              ram_we_o    <= dbg_we_i;
              ram_addr_o  <= dbg_addr_i[ADDR_W-1:2];
              ram_be_o    <= 4'b1111;
              ram_wdata_o <= dbg_wdata_i;
              state       <= ST_REQ;
            end else begin
              last_owner  <= OWN_PIPE;
`else
            begin
`endif
              owner <= OWN_PIPE;
              if (pipe_bad) begin
                pipe_done_o  <= 1'b1;
                pipe_err_o   <= 1'b1;
                pipe_rdata_o <= '0;
                state        <= ST_DONE;
              end else begin
                cur_funct3  <= pipe_funct3_i;
                cur_addr_lo <= pipe_addr_i[1:0];
                ram_req_o   <= 1'b1;
                ram_we_o    <= pipe_we_i;
                ram_addr_o  <= pipe_addr_i[ADDR_W-1:2];
                ram_be_o    <= pipe_be;
                ram_wdata_o <= pipe_wdata_rep;
                state       <= ST_REQ;
              end
            end
          end
        end

        ST_REQ: begin
          cnt <= cnt + 1'b1;
          if (ram_gnt_i) begin
            ram_req_o <= 1'b0;
            state     <= ST_WAIT;
          end else if (timeout_hit) begin
            ram_req_o <= 1'b0;
            state     <= ST_DONE;
`ifdef DMEM_DBG_PORT_EN
            if (owner == OWN_DBG) begin
              dbg_done_o  <= 1'b1;
              dbg_rdata_o <= '0;
            end else
`endif
            begin
              pipe_done_o  <= 1'b1;
              pipe_err_o   <= 1'b1;
              pipe_rdata_o <= '0;
            end
          end
        end

        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          if (ram_rvalid_i || timeout_hit) begin
            state <= ST_DONE;
`ifdef DMEM_DBG_PORT_EN
            if (owner == OWN_DBG) begin
              dbg_done_o  <= 1'b1;
              dbg_rdata_o <= ram_rvalid_i ? ram_rdata_i : '0;
            end else
`endif
            begin
              pipe_done_o  <= 1'b1;
              pipe_err_o   <= !ram_rvalid_i;
              pipe_rdata_o <= ram_rvalid_i ? rdata_ext : '0;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: table-driven pipeline accesses plus hand-written
// timeout, reset-abort and arbitration sequences against a small RAM model.
module tb_dmem_ctrl;

  localparam int ADDR_W = 32;
  localparam int TO_CYC = 4;
  localparam int NV     = 18;

  logic              clk = 1'b0;
  logic              arst;
  logic              pipe_req, pipe_we;
  logic [2:0]        pipe_funct3;
  logic [ADDR_W-1:0] pipe_addr;
  logic [31:0]       pipe_wdata;
  logic              pipe_stall, pipe_done, pipe_err;
  logic [31:0]       pipe_rdata;
`ifdef DMEM_DBG_PORT_EN
  logic              dbg_req, dbg_we, dbg_done;
  logic [ADDR_W-1:0] dbg_addr;
  logic [31:0]       dbg_wdata, dbg_rdata;
`endif
  logic              ram_req, ram_we, ram_gnt, ram_rvalid;
  logic [ADDR_W-3:0] ram_addr;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata, ram_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO_CYC)) u_dut (
    .clk           (clk),
    .arst          (arst),
    .pipe_req_i    (pipe_req),
    .pipe_we_i     (pipe_we),
    .pipe_funct3_i (pipe_funct3),
    .pipe_addr_i   (pipe_addr),
    .pipe_wdata_i  (pipe_wdata),
    .pipe_stall_o  (pipe_stall),
    .pipe_done_o   (pipe_done),
    .pipe_err_o    (pipe_err),
    .pipe_rdata_o  (pipe_rdata),
`ifdef DMEM_DBG_PORT_EN
    .dbg_req_i     (dbg_req),
    .dbg_we_i      (dbg_we),
    .dbg_addr_i    (dbg_addr),
    .dbg_wdata_i   (dbg_wdata),
    .dbg_done_o    (dbg_done),
    .dbg_rdata_o   (dbg_rdata),
`endif
    .ram_req_o     (ram_req),
    .ram_we_o      (ram_we),
    .ram_addr_o    (ram_addr),
    .ram_be_o      (ram_be),
    .ram_wdata_o   (ram_wdata),
    .ram_gnt_i     (ram_gnt),
    .ram_rvalid_i  (ram_rvalid),
    .ram_rdata_i   (ram_rdata)
  );

  // RAM model: grant follows the request combinationally, rvalid one cycle later.
  logic [31:0] mem [0:255];
  logic        gnt_en       = 1'b1;
  logic        rvalid_q     = 1'b0;
  logic        rvalid_force = 1'b0;
  logic        pre_en       = 1'b0;
  logic [7:0]  pre_idx      = '0;
  logic [31:0] pre_val      = '0;
  logic [ADDR_W-3:0] grant_log[$];

  assign ram_gnt    = ram_req & gnt_en;
  assign ram_rvalid = rvalid_q | rvalid_force;

  always @(posedge clk) begin
    rvalid_q <= 1'b0;
    if (pre_en) mem[pre_idx] <= pre_val;
    if (ram_req && ram_gnt) begin
      rvalid_q  <= 1'b1;
      ram_rdata <= mem[ram_addr[7:0]];
      if (ram_we)
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
      grant_log.push_back(ram_addr);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    pre_idx = idx;
    pre_val = val;
    pre_en  = 1'b1;
    tick();
    pre_en  = 1'b0;
  endtask

  task automatic pipe_drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd);
    pipe_we     = we;
    pipe_funct3 = f3;
    pipe_addr   = addr;
    pipe_wdata  = wd;
    pipe_req    = 1'b1;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pre;
    logic [31:0] word;
    logic        err;
    logic [3:0]  be;
    logic [31:0] wexp;
    logic [31:0] rexp;
  } vec_t;

  vec_t vt [NV];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int n, stable, pd, dd;

    //          we    f3      addr        wdata          pre   word           err   be       wexp           rexp
    vt[0]  = '{1'b0, 3'b010, 32'h100, 32'h0,         1'b1, 32'hDEADBEEF, 1'b0, 4'b1111, 32'h0,         32'hDEADBEEF};
    vt[1]  = '{1'b0, 3'b000, 32'h103, 32'h0,         1'b1, 32'h80FF1234, 1'b0, 4'b1000, 32'h0,         32'hFFFFFF80};
    vt[2]  = '{1'b0, 3'b100, 32'h103, 32'h0,         1'b0, 32'h0,        1'b0, 4'b1000, 32'h0,         32'h00000080};
    vt[3]  = '{1'b0, 3'b001, 32'h102, 32'h0,         1'b0, 32'h0,        1'b0, 4'b1100, 32'h0,         32'hFFFF80FF};
    vt[4]  = '{1'b0, 3'b101, 32'h100, 32'h0,         1'b0, 32'h0,        1'b0, 4'b0011, 32'h0,         32'h00001234};
    vt[5]  = '{1'b0, 3'b000, 32'h100, 32'h0,         1'b0, 32'h0,        1'b0, 4'b0001, 32'h0,         32'h00000034};
    vt[6]  = '{1'b1, 3'b001, 32'h102, 32'h0000ABCD,  1'b0, 32'h0,        1'b0, 4'b1100, 32'hABCDABCD,  32'h0};
    vt[7]  = '{1'b0, 3'b010, 32'h100, 32'h0,         1'b0, 32'h0,        1'b0, 4'b1111, 32'h0,         32'hABCD1234};
    vt[8]  = '{1'b1, 3'b000, 32'h101, 32'h000000EE,  1'b0, 32'h0,        1'b0, 4'b0010, 32'hEEEEEEEE,  32'h0};
    vt[9]  = '{1'b0, 3'b000, 32'h101, 32'h0,         1'b0, 32'h0,        1'b0, 4'b0010, 32'h0,         32'hFFFFFFEE};
    vt[10] = '{1'b1, 3'b010, 32'h104, 32'h12345678,  1'b0, 32'h0,        1'b0, 4'b1111, 32'h12345678,  32'h0};
    vt[11] = '{1'b0, 3'b101, 32'h106, 32'h0,         1'b0, 32'h0,        1'b0, 4'b1100, 32'h0,         32'h00001234};
    vt[12] = '{1'b0, 3'b010, 32'h101, 32'h0,         1'b0, 32'h0,        1'b1, 4'b0000, 32'h0,         32'h0};
    vt[13] = '{1'b0, 3'b001, 32'h103, 32'h0,         1'b0, 32'h0,        1'b1, 4'b0000, 32'h0,         32'h0};
    vt[14] = '{1'b0, 3'b011, 32'h100, 32'h0,         1'b0, 32'h0,        1'b1, 4'b0000, 32'h0,         32'h0};
    vt[15] = '{1'b0, 3'b110, 32'h100, 32'h0,         1'b0, 32'h0,        1'b1, 4'b0000, 32'h0,         32'h0};
    vt[16] = '{1'b0, 3'b111, 32'h100, 32'h0,         1'b0, 32'h0,        1'b1, 4'b0000, 32'h0,         32'h0};
    vt[17] = '{1'b1, 3'b010, 32'h102, 32'h55555555,  1'b0, 32'h0,        1'b1, 4'b0000, 32'h0,         32'h0};

    arst = 1'b1;
    pipe_req = 1'b0; pipe_we = 1'b0; pipe_funct3 = 3'b000; pipe_addr = '0; pipe_wdata = '0;
`ifdef DMEM_DBG_PORT_EN
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
`endif

    // Reset state.
    tick(); tick();
    check("rst_ram_req",   ram_req,   1'b0);
    check("rst_ram_we",    ram_we,    1'b0);
    check("rst_ram_addr",  32'(ram_addr), 32'h0);
    check("rst_ram_be",    32'(ram_be), 32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    check("rst_pipe_done", pipe_done, 1'b0);
    check("rst_pipe_err",  pipe_err,  1'b0);
    check("rst_pipe_rdata", pipe_rdata, 32'h0);
    check("rst_stall_idle", pipe_stall, 1'b0);
`ifdef DMEM_DBG_PORT_EN
    check("rst_dbg_done",  dbg_done,  1'b0);
    check("rst_dbg_rdata", dbg_rdata, 32'h0);
`endif
    pipe_req = 1'b1;
    #1;
    check("rst_stall_req", pipe_stall, 1'b1);
    pipe_req = 1'b0;
    tick();
    arst = 1'b0;
    tick();

    // Table-driven pipeline accesses with immediate grant and rvalid one cycle later.
    for (int i = 0; i < NV; i++) begin
      v = vt[i];
      if (v.pre) preload(v.addr[9:2], v.word);
      pipe_drive(v.we, v.f3, v.addr, v.wdata);
      #1;
      check($sformatf("v%0d_c0_stall", i), pipe_stall, 1'b1);
      tick();
      if (v.err) begin
        check($sformatf("v%0d_err_no_req", i), ram_req,    1'b0);
        check($sformatf("v%0d_err_done", i),   pipe_done,  1'b1);
        check($sformatf("v%0d_err_flag", i),   pipe_err,   1'b1);
        check($sformatf("v%0d_err_rdata", i),  pipe_rdata, 32'h0);
        check($sformatf("v%0d_err_stall", i),  pipe_stall, 1'b0);
      end else begin
        check($sformatf("v%0d_c1_req", i),   ram_req, 1'b1);
        check($sformatf("v%0d_c1_we", i),    ram_we,  v.we);
        check($sformatf("v%0d_c1_addr", i),  32'(ram_addr), {2'b00, v.addr[31:2]});
        check($sformatf("v%0d_c1_be", i),    32'(ram_be), 32'(v.be));
        if (v.we) check($sformatf("v%0d_c1_wdata", i), ram_wdata, v.wexp);
        check($sformatf("v%0d_c1_stall", i), pipe_stall, 1'b1);
        check($sformatf("v%0d_c1_done", i),  pipe_done,  1'b0);
        tick();
        check($sformatf("v%0d_c2_req", i),   ram_req,    1'b0);
        check($sformatf("v%0d_c2_stall", i), pipe_stall, 1'b1);
        check($sformatf("v%0d_c2_done", i),  pipe_done,  1'b0);
        tick();
        check($sformatf("v%0d_c3_done", i),  pipe_done,  1'b1);
        check($sformatf("v%0d_c3_err", i),   pipe_err,   1'b0);
        check($sformatf("v%0d_c3_stall", i), pipe_stall, 1'b0);
        if (!v.we) check($sformatf("v%0d_c3_rdata", i), pipe_rdata, v.rexp);
      end
      pipe_req = 1'b0;
      tick();
      check($sformatf("v%0d_after_done", i), pipe_done, 1'b0);
    end

    // Stray rvalid while idle must be ignored.
    rvalid_force = 1'b1;
    tick();
    rvalid_force = 1'b0;
    check("stray_rvalid_done", pipe_done, 1'b0);
    check("stray_rvalid_req",  ram_req,   1'b0);

    // Timeout: grant never arrives, request held stable then dropped with an error.
    gnt_en = 1'b0;
    pipe_drive(1'b0, 3'b010, 32'h100, 32'h0);
    tick();
    n = 0;
    stable = 1;
    while (ram_req && n < 20) begin
      n++;
      if (ram_addr !== 30'h40 || ram_be !== 4'b1111) stable = 0;
      tick();
    end
    check("to_req_cycles", n, TO_CYC);
    check("to_req_stable", stable, 1);
    check("to_req_dropped", ram_req, 1'b0);
    check("to_done", pipe_done, 1'b1);
    check("to_err",  pipe_err,  1'b1);
    check("to_stall", pipe_stall, 1'b0);
    pipe_req = 1'b0;
    tick();
    check("to_done_pulse", pipe_done, 1'b0);

    // Reset while in REQ: the RAM request drops without waiting for a clock.
    pipe_drive(1'b0, 3'b010, 32'h100, 32'h0);
    tick();
    check("rstreq_req_high", ram_req, 1'b1);
    arst = 1'b1;
    #1;
    check("rstreq_req_async", ram_req, 1'b0);
    pipe_req = 1'b0;
    gnt_en = 1'b1;
    tick();
    arst = 1'b0;
    tick();
    check("rstreq_no_done", pipe_done, 1'b0);

    // Reset while in WAIT: no completion pulse, outputs cleared.
    pipe_drive(1'b0, 3'b010, 32'h100, 32'h0);
    tick();
    tick();
    check("rstwait_in_wait", ram_rvalid, 1'b1);
    arst = 1'b1;
    #1;
    check("rstwait_req",   ram_req,    1'b0);
    check("rstwait_done",  pipe_done,  1'b0);
    check("rstwait_rdata", pipe_rdata, 32'h0);
    pipe_req = 1'b0;
    tick();
    check("rstwait_done_held", pipe_done, 1'b0);
    arst = 1'b0;
    tick();
    check("rstwait_done_after", pipe_done, 1'b0);
    check("rstwait_be_after",   32'(ram_be), 32'h0);

    // Continuous requests: grants must alternate (pipeline first) when debug exists.
    preload(8'h40, 32'h0BADC0DE);
    preload(8'h80, 32'hCAFEF00D);
    grant_log.delete();
    pd = 0;
    dd = 0;
    pipe_drive(1'b0, 3'b010, 32'h100, 32'h0);
`ifdef DMEM_DBG_PORT_EN
    dbg_req  = 1'b1;
    dbg_we   = 1'b0;
    dbg_addr = 32'h203;
`endif
    for (int c = 0; c < 12; c++) begin
      tick();
      if (pipe_done) begin
        pd++;
        check("arb_pipe_rdata", pipe_rdata, 32'h0BADC0DE);
      end
`ifdef DMEM_DBG_PORT_EN
      if (dbg_done) begin
        dd++;
        check("arb_dbg_rdata", dbg_rdata, 32'hCAFEF00D);
      end
      if (ram_req && ram_addr == 30'h80) check("arb_dbg_be", 32'(ram_be), 32'hF);
`endif
    end
    pipe_req = 1'b0;
`ifdef DMEM_DBG_PORT_EN
    dbg_req = 1'b0;
`endif
    check("arb_grants", grant_log.size(), 3);
    check("arb_grant0", 32'(grant_log[0]), 32'h40);
`ifdef DMEM_DBG_PORT_EN
    check("arb_grant1", 32'(grant_log[1]), 32'h80);
    check("arb_pipe_dones", pd, 2);
    check("arb_dbg_dones",  dd, 1);
`else
    check("arb_grant1", 32'(grant_log[1]), 32'h40);
    check("arb_pipe_dones", pd, 3);
`endif
    check("arb_grant2", 32'(grant_log[2]), 32'h40);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access controller between the MEM pipeline stage and the single-port data RAM. It sequences each load/store onto a variable-latency request/grant/valid RAM interface and builds byte enables and load extension from funct3. It stalls the pipeline until the access completes. It also arbitrates the RAM round-robin against a debug/loader port.

## Interface
Parameters:
- `ADDR_W`, default 32: byte-address width. The RAM address is `ADDR_W-2` bits wide (word address).
- `TIMEOUT_CYC`, default 255: maximum number of cycles spent in REQ+WAIT before the access is aborted. A value of 0 disables the timeout.

Ports:
- `clk` in 1: the single clock.
- `arst` in 1: reset, asynchronous and active-high.
- `pipe_req_i` in 1: the MEM stage holds a load/store.
- `pipe_we_i` in 1: 1 = store.
- `pipe_funct3_i` in 3: access size and signedness.
- `pipe_addr_i` in ADDR_W: byte address.
- `pipe_wdata_i` in 32: store data, right-aligned.
- `pipe_stall_o` out 1: freezes the pipeline.
- `pipe_done_o` out 1: one-cycle completion pulse.
- `pipe_err_o` out 1: error qualifier, valid with `pipe_done_o`.
- `pipe_rdata_o` out 32: extended load data, valid with `pipe_done_o`.
- `dbg_req_i` in 1, `dbg_we_i` in 1, `dbg_addr_i` in ADDR_W, `dbg_wdata_i` in 32: debug requester. Word accesses only; `dbg_addr_i[1:0]` is ignored.
- `dbg_done_o` out 1, `dbg_rdata_o` out 32: debug completion pulse and read data.
- `ram_req_o` out 1, `ram_we_o` out 1, `ram_addr_o` out ADDR_W-2, `ram_be_o` out 4, `ram_wdata_o` out 32: RAM request side.
- `ram_gnt_i` in 1, `ram_rvalid_i` in 1, `ram_rdata_i` in 32: RAM response side. Stores are also acknowledged with `ram_rvalid_i`.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: if any request is pending, arbitrate, capture the winner's address, byte enables, write data and owner, then go to REQ.
  - REQ: drive `ram_req_o`. On `ram_gnt_i`, go to WAIT.
  - WAIT: on `ram_rvalid_i`, capture `ram_rdata_i` and go to DONE.
  - DONE: pulse the owner's done output, then go to IDLE.
- Arbitration: if only one port requests, it wins. If both request, the port not served last wins. `last_owner` resets to DBG, so the pipeline wins the first conflict.
- Pipeline error checks, all resolved in IDLE:
  - Misaligned access: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Illegal funct3: 011, 110, 111.
  - On either error, go straight from IDLE to DONE with `pipe_err_o`=1 and `pipe_rdata_o`=0. No RAM cycle is issued.
- Byte enables:
  - SB: `4'b0001<<addr[1:0]`, with the write byte replicated across all four lanes.
  - SH: `4'b0011<<{addr[1],1'b0}`, with the write halfword replicated across both halves.
  - SW: `4'b1111`.
  - Loads drive the same enables for their size.
- Load extension: select the lane from `addr[1:0]`. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Timeout:
  - A cycle counter runs in REQ and WAIT.
  - When it reaches `TIMEOUT_CYC`, drop `ram_req_o` and go to DONE with the error flag set.
  - `ram_rvalid_i` arriving outside WAIT is discarded.
- Stall: `pipe_stall_o = pipe_req_i && !(state==DONE && owner==PIPE)`, combinational. It is released exactly in the pipeline's DONE cycle.

## Timing
- Reset values:
  - State IDLE, counter 0, `last_owner`=DBG.
  - All `ram_*` outputs 0, `pipe_done_o`/`pipe_err_o`/`pipe_rdata_o` 0, `dbg_done_o`/`dbg_rdata_o` 0.
  - `pipe_stall_o` follows its equation.
- Reset asserted mid-access aborts immediately. No done pulse is produced, and the RAM request drops in the same cycle.
- Minimum latency, pipeline access (`ram_gnt_i` in the first REQ cycle, `ram_rvalid_i` one cycle later):
  - c0: request seen in IDLE.
  - c1: `ram_req_o` high and granted.
  - c2: WAIT, `ram_rvalid_i` high.
  - c3: DONE, with `pipe_done_o` high and `pipe_stall_o` low.
- Error accesses complete at c1.
- `ram_*` request outputs are registered and held stable from REQ entry until grant.
- `ram_rvalid_i` is never expected in the same cycle as `ram_gnt_i`.
- A new request is sampled no earlier than the IDLE cycle after DONE. Back-to-back pipeline accesses therefore take 4 cycles each.
- Requesters hold their inputs stable until they see done.

## Configuration
- `DMEM_DBG_PORT_EN` defined: the `dbg_*` ports, round-robin arbitration and `last_owner` exist.
- `DMEM_DBG_PORT_EN` undefined: the `dbg_*` ports are absent, the pipeline is always the owner, and all pipeline behaviour and timing are unchanged.

## Structure
- Shared define file holds:
  - funct3 codes (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - FSM state encodings.
  - Owner codes.
  - Existing `MEM` / `MEM_ADDR` width macros.
- Sub-module `dmem_lane_align`: combinational byte-enable generation, write-data replication and load extension.

## Test plan
- LW at 0x100 with rdata 0xDEADBEEF, gnt immediate, rvalid +1 → `ram_addr_o`=0x40, `ram_be_o`=1111, done at c3, `pipe_rdata_o`=0xDEADBEEF, stall high c0–c2.
- LB at 0x103 with word 0x80FF_1234 → `pipe_rdata_o`=0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x102 with wdata 0x0000ABCD → `ram_be_o`=1100, `ram_wdata_o`=0xABCDABCD, `ram_we_o`=1.
- LW at 0x101 → no `ram_req_o`, done with `pipe_err_o`=1 at c1. Likewise funct3=011 → error.
- Pipeline and debug both request continuously → grants alternate PIPE, DBG, PIPE. Run with and without `DMEM_DBG_PORT_EN`.
- `TIMEOUT_CYC`=4 with gnt never asserted → `ram_req_o` drops and error done pulses. Separately, `arst` asserted in WAIT → outputs clear and no done pulse.
